// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between icache refills and dcache refill/writeback.
// Latency: grant is combinational in IDLE; mem request is presented one cycle after acceptance; beats pass through combinationally.
// Backpressure: one transaction in flight; both request readys are low outside IDLE; write beats stall on either side's handshake.
// Build option: define ARB_RR_EN for round-robin on contention; otherwise dcache has fixed priority.

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  // icache request / response
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  // dcache request / response / write data
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  input  logic              dc_wdata_valid,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_ready,
  // shared read data
  output logic [DATA_W-1:0] resp_data,
  // memory side
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              mem_wdata_valid,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wdata_ready
);

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RD   = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;      // 0 = icache, 1 = dcache
  logic                r_last_dc;    // owner of the most recent grant
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_beat_cnt;

  logic                w_pick_ic;    // who wins when both caches request together
  logic                w_grant_ic;
  logic                w_grant_dc;
  logic                w_rd_beat;
  logic                w_wr_beat;
  logic                w_last_beat;

`ifdef ARB_RR_EN
  // Round-robin: the cache that did not win last time gets the contended slot.
  assign w_pick_ic = r_last_dc;
`else
  // Fixed priority: dcache always wins; last_dc is still tracked so both builds share state.
  assign w_pick_ic = r_last_dc & 1'b0;
`endif

  // Combinational grant, only in IDLE and never while reset is asserted.
  always_comb begin
    w_grant_ic = 1'b0;
    w_grant_dc = 1'b0;
    if (!reset && (r_state == S_IDLE)) begin
      w_grant_dc = dc_req_valid && (!ic_req_valid || !w_pick_ic);
      w_grant_ic = ic_req_valid && (!dc_req_valid ||  w_pick_ic);
    end
  end

  assign w_rd_beat   = (r_state == S_RD) && mem_resp_valid;
  assign w_wr_beat   = (r_state == S_WR) && dc_wdata_valid && mem_wdata_ready;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one transaction at a time, exit after the final beat.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_ic || w_grant_dc) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_next_state = r_rw ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (w_rd_beat && w_last_beat) begin
          w_next_state = S_IDLE;
        end
      end
      S_WR: begin
        if (w_wr_beat && w_last_beat) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode; every valid/ready is forced low during the reset cycle.
  always_comb begin
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    ic_resp_valid   = 1'b0;
    dc_resp_valid   = 1'b0;
    mem_req_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    dc_wdata_ready  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          ic_req_ready = w_grant_ic;
          dc_req_ready = w_grant_dc;
        end
        S_REQ: begin
          mem_req_valid = 1'b1;
        end
        S_RD: begin
          ic_resp_valid = mem_resp_valid && !r_owner;
          dc_resp_valid = mem_resp_valid &&  r_owner;
        end
        S_WR: begin
          mem_wdata_valid = dc_wdata_valid;
          dc_wdata_ready  = mem_wdata_ready;
        end
        default: begin
          ic_req_ready = 1'b0;
        end
      endcase
    end
  end

  // Transaction context: latched at grant, held for the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner   <= 1'b0;
      r_last_dc <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
    end else if (w_grant_ic || w_grant_dc) begin
      r_owner   <= w_grant_dc;
      r_last_dc <= w_grant_dc;
      r_rw      <= w_grant_dc && dc_req_rw;   // icache traffic is always a read
      r_addr    <= w_grant_dc ? dc_req_addr : ic_req_addr;
    end
  end

  // Beat counter: cleared when memory accepts the request, stepped per completed beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if ((r_state == S_REQ) && mem_req_ready) begin
      r_beat_cnt <= '0;
    end else if (w_rd_beat || w_wr_beat) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign mem_req_rw   = r_rw;
  assign mem_req_addr = r_addr;
  assign mem_wdata    = dc_wdata;
  assign resp_data    = mem_resp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed transactions with a scoreboard of expected port events.
// Latency: expected events are queued by stimulus and consumed by a negedge monitor.
// Backpressure: memory-side readys and dcache write-data gaps are driven from small tables.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;

  localparam logic [2:0] K_IC_GNT = 3'd1;
  localparam logic [2:0] K_DC_GNT = 3'd2;
  localparam logic [2:0] K_MEMREQ = 3'd3;
  localparam logic [2:0] K_IC_BT  = 3'd4;
  localparam logic [2:0] K_DC_BT  = 3'd5;
  localparam logic [2:0] K_WBEAT  = 3'd6;

  typedef struct packed {
    logic [2:0]    kind;
    logic [DW-1:0] dat;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic          dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic          dc_wdata_valid, dc_wdata_ready;
  logic [DW-1:0] dc_wdata, resp_data;
  logic          mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid, mem_wdata_valid, mem_wdata_ready;
  logic [DW-1:0] mem_resp_data, mem_wdata;

  // Second instance with single-beat transactions.
  logic          b_ic_req_valid, b_ic_req_ready, b_ic_resp_valid;
  logic [AW-1:0] b_ic_req_addr;
  logic          b_dc_req_valid, b_dc_req_rw, b_dc_req_ready, b_dc_resp_valid;
  logic [AW-1:0] b_dc_req_addr;
  logic          b_dc_wdata_valid, b_dc_wdata_ready;
  logic [DW-1:0] b_dc_wdata, b_resp_data;
  logic          b_mem_req_valid, b_mem_req_rw, b_mem_req_ready;
  logic [AW-1:0] b_mem_req_addr;
  logic          b_mem_resp_valid, b_mem_wdata_valid, b_mem_wdata_ready;
  logic [DW-1:0] b_mem_resp_data, b_mem_wdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_ready(dc_req_ready), .dc_resp_valid(dc_resp_valid),
    .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata), .dc_wdata_ready(dc_wdata_ready),
    .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(1)) dut1 (
    .clk(clk), .reset(reset),
    .ic_req_valid(b_ic_req_valid), .ic_req_addr(b_ic_req_addr), .ic_req_ready(b_ic_req_ready),
    .ic_resp_valid(b_ic_resp_valid),
    .dc_req_valid(b_dc_req_valid), .dc_req_rw(b_dc_req_rw), .dc_req_addr(b_dc_req_addr),
    .dc_req_ready(b_dc_req_ready), .dc_resp_valid(b_dc_resp_valid),
    .dc_wdata_valid(b_dc_wdata_valid), .dc_wdata(b_dc_wdata), .dc_wdata_ready(b_dc_wdata_ready),
    .resp_data(b_resp_data),
    .mem_req_valid(b_mem_req_valid), .mem_req_rw(b_mem_req_rw), .mem_req_addr(b_mem_req_addr),
    .mem_req_ready(b_mem_req_ready), .mem_resp_valid(b_mem_resp_valid), .mem_resp_data(b_mem_resp_data),
    .mem_wdata_valid(b_mem_wdata_valid), .mem_wdata(b_mem_wdata), .mem_wdata_ready(b_mem_wdata_ready)
  );

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  tb_last_dc = 1'b0;
  logic [1:0] wpat [0:6];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [DW-1:0] dat);
    ev_t e;
    e.kind = kind;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  task automatic push_gnt(input bit is_dc, input logic rw, input logic [AW-1:0] addr);
    if (is_dc) push(K_DC_GNT, DW'({rw, addr}));
    else       push(K_IC_GNT, DW'(addr));
    tb_last_dc = is_dc;
  endtask

  // Monitor: every observed DUT event must match the head of the expected queue.
  task automatic see(input logic [2:0] kind, input logic [DW-1:0] dat);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got kind %0d data %0h expected no event", kind, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.dat !== dat) begin
        n_err++;
        $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h", kind, dat, e.kind, e.dat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ic_req_valid && ic_req_ready)       see(K_IC_GNT, DW'(ic_req_addr));
    if (dc_req_valid && dc_req_ready)       see(K_DC_GNT, DW'({dc_req_rw, dc_req_addr}));
    if (mem_req_valid && mem_req_ready)     see(K_MEMREQ, DW'({mem_req_rw, mem_req_addr}));
    if (ic_resp_valid)                      see(K_IC_BT, resp_data);
    if (dc_resp_valid)                      see(K_DC_BT, resp_data);
    if (mem_wdata_valid && mem_wdata_ready) see(K_WBEAT, mem_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request phase: hold mem_req_ready low for 'delay' cycles, checking the request stays stable.
  task automatic req_phase(input int delay, input logic [AW-1:0] addr, input logic rw);
    push(K_MEMREQ, DW'({rw, addr}));
    for (int k = 0; k <= delay; k++) begin
      mem_req_ready = (k == delay);
      #2;
      chk("req_valid", DW'(mem_req_valid), DW'(1'b1));
      chk("req_addr", DW'(mem_req_addr), DW'(addr));
      chk("req_rw", DW'(mem_req_rw), DW'(rw));
      tick();
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic read_beats(input bit is_dc, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push(is_dc ? K_DC_BT : K_IC_BT, base + DW'(i));
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + DW'(i);
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            win_dc;
    int            w;
    logic [AW-1:0] a;
    wpat[0] = 2'b11; wpat[1] = 2'b01; wpat[2] = 2'b10; wpat[3] = 2'b11;
    wpat[4] = 2'b11; wpat[5] = 2'b00; wpat[6] = 2'b11;

    reset = 1'b1;
    ic_req_valid = 1'b1; ic_req_addr = 32'h40;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0;
    dc_wdata_valid = 1'b0; dc_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_wdata_ready = 1'b0;
    b_ic_req_valid = 1'b0; b_ic_req_addr = '0;
    b_dc_req_valid = 1'b0; b_dc_req_rw = 1'b0; b_dc_req_addr = '0;
    b_dc_wdata_valid = 1'b0; b_dc_wdata = '0;
    b_mem_req_ready = 1'b0; b_mem_resp_valid = 1'b0; b_mem_resp_data = '0; b_mem_wdata_ready = 1'b0;

    // Reset state
    tick(); tick();
    #2;
    chk("rst_ic_ready", DW'(ic_req_ready), DW'(1'b0));
    chk("rst_mem_req_valid", DW'(mem_req_valid), DW'(1'b0));
    tick();
    reset = 1'b0; ic_req_valid = 1'b0;
    #2;
    chk("rst_addr", DW'(mem_req_addr), DW'(0));
    chk("rst_rw", DW'(mem_req_rw), DW'(0));
    chk("rst_req_valid", DW'(mem_req_valid), DW'(0));
    chk("rst_wdata_ready", DW'(dc_wdata_ready), DW'(0));
    tick();

    // icache read alone, memory accepts 2 cycles late, spurious resp during REQ
    push_gnt(1'b0, 1'b0, 32'h40);
    ic_req_valid = 1'b1; ic_req_addr = 32'h40;
    #2;
    chk("t1_ic_ready", DW'(ic_req_ready), DW'(1'b1));
    chk("t1_dc_ready", DW'(dc_req_ready), DW'(1'b0));
    tick();
    ic_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 128'hDEAD;
    req_phase(2, 32'h40, 1'b0);
    mem_resp_valid = 1'b0;
    tick();                                    // gap before first beat
    read_beats(1'b0, 128'h100, 3);
    push(K_IC_BT, 128'h103);
    mem_resp_valid = 1'b1; mem_resp_data = 128'h103;
    ic_req_valid = 1'b1; ic_req_addr = 32'h80;
    #2;
    chk("t1_ready_on_last_beat", DW'(ic_req_ready), DW'(1'b0));
    tick();
    mem_resp_valid = 1'b0;
    push_gnt(1'b0, 1'b0, 32'h80);
    #2;
    chk("t1_ready_after_last", DW'(ic_req_ready), DW'(1'b1));
    tick();
    ic_req_valid = 1'b0;
    req_phase(0, 32'h80, 1'b0);
    read_beats(1'b0, 128'h200, 4);

    // Spurious memory beat while IDLE
    mem_resp_valid = 1'b1; mem_resp_data = 128'hBAD;
    tick();
    mem_resp_valid = 1'b0;

    // dcache writeback with data gaps and memory stalls
    push_gnt(1'b1, 1'b1, 32'h1000);
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 32'h1000;
    #2;
    chk("t2_dc_ready", DW'(dc_req_ready), DW'(1'b1));
    tick();
    dc_req_valid = 1'b0;
    req_phase(1, 32'h1000, 1'b1);
    w = 0;
    for (int i = 0; i < 7; i++) begin
      dc_wdata_valid  = wpat[i][1];
      mem_wdata_ready = wpat[i][0];
      dc_wdata        = 128'hA000 + DW'(w);
      if (wpat[i] == 2'b11) push(K_WBEAT, 128'hA000 + DW'(w));
      #2;
      chk("t2_mem_wdata_valid", DW'(mem_wdata_valid), DW'(wpat[i][1]));
      chk("t2_dc_wdata_ready", DW'(dc_wdata_ready), DW'(wpat[i][0]));
      tick();
      if (wpat[i] == 2'b11) w++;
    end
    dc_wdata_valid = 1'b1; mem_wdata_ready = 1'b1;
    #2;
    chk("t2_idle_wvalid", DW'(mem_wdata_valid), DW'(1'b0));
    chk("t2_idle_wready", DW'(dc_wdata_ready), DW'(1'b0));
    tick();
    dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0; dc_req_rw = 1'b0;

    // Contention: both caches request continuously
    ic_req_valid = 1'b1; ic_req_addr = 32'h3000;
    dc_req_valid = 1'b1; dc_req_addr = 32'h2000;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
      win_dc = !tb_last_dc;
`else
      win_dc = 1'b1;
`endif
      a = win_dc ? 32'h2000 : 32'h3000;
      push_gnt(win_dc, 1'b0, a);
      #2;
      chk("t3_ic_ready", DW'(ic_req_ready), DW'(!win_dc));
      chk("t3_dc_ready", DW'(dc_req_ready), DW'(win_dc));
      tick();
      req_phase(0, a, 1'b0);
      read_beats(win_dc, 128'h300 + DW'(g * 16), 4);
    end
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    tick();

    // Reset in the middle of a dcache read, then an immediate icache request
    push_gnt(1'b1, 1'b0, 32'h4000);
    dc_req_valid = 1'b1; dc_req_addr = 32'h4000;
    #2;
    chk("t4_dc_ready", DW'(dc_req_ready), DW'(1'b1));
    tick();
    dc_req_valid = 1'b0;
    req_phase(0, 32'h4000, 1'b0);
    read_beats(1'b1, 128'h400, 2);
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 128'h402;
    ic_req_valid = 1'b1; ic_req_addr = 32'h5000;
    dc_wdata_valid = 1'b1; mem_wdata_ready = 1'b1;
    #2;
    chk("t4_rst_dc_resp", DW'(dc_resp_valid), DW'(1'b0));
    chk("t4_rst_ic_ready", DW'(ic_req_ready), DW'(1'b0));
    chk("t4_rst_req_valid", DW'(mem_req_valid), DW'(1'b0));
    chk("t4_rst_wready", DW'(dc_wdata_ready), DW'(1'b0));
    tick();
    reset = 1'b0;
    push_gnt(1'b0, 1'b0, 32'h5000);
    #2;
    chk("t4_post_dc_resp", DW'(dc_resp_valid), DW'(1'b0));
    chk("t4_post_req_valid", DW'(mem_req_valid), DW'(1'b0));
    chk("t4_post_addr", DW'(mem_req_addr), DW'(0));
    chk("t4_post_ic_ready", DW'(ic_req_ready), DW'(1'b1));
    tick();
    ic_req_valid = 1'b0; mem_resp_valid = 1'b0;
    dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0;
    req_phase(1, 32'h5000, 1'b0);
    read_beats(1'b0, 128'h500, 4);

    // BEATS=1 instance: single-beat dcache read, then immediate re-grant
    b_dc_req_valid = 1'b1; b_dc_req_addr = 32'h60;
    #2;
    chk("t5_ready", DW'(b_dc_req_ready), DW'(1'b1));
    tick();
    b_mem_req_ready = 1'b1;
    #2;
    chk("t5_ready_in_req", DW'(b_dc_req_ready), DW'(1'b0));
    chk("t5_req_valid", DW'(b_mem_req_valid), DW'(1'b1));
    chk("t5_req_addr", DW'(b_mem_req_addr), DW'(32'h60));
    tick();
    b_mem_req_ready = 1'b0;
    b_mem_resp_valid = 1'b1; b_mem_resp_data = 128'h777;
    #2;
    chk("t5_resp_valid", DW'(b_dc_resp_valid), DW'(1'b1));
    chk("t5_resp_data", b_resp_data, 128'h777);
    chk("t5_ic_resp", DW'(b_ic_resp_valid), DW'(1'b0));
    tick();
    b_mem_resp_valid = 1'b0;
    #2;
    chk("t5_ready_again", DW'(b_dc_req_ready), DW'(1'b1));
    chk("t5_resp_after", DW'(b_dc_resp_valid), DW'(1'b0));
    tick();
    b_dc_req_valid = 1'b0;

    // Drain scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d events outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
